// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU control codes, forwarding selects and datapath width
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // 2'b11 is not a real source; the stage treats it like FWD_IDEX.
  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: control code and operands to result and zero flag
module alu_core
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_alu_stage.sv
// rtl/execute_alu_stage.sv - EX stage: operand forwarding, immediate select, ALU, BEQ resolve, EX/MEM register
module execute_alu_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [3:0]      i_alu_control,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_alu_src,
  input  logic [1:0]      i_fwd_a,
  input  logic [1:0]      i_fwd_b,
  input  logic [XLEN-1:0] i_mem_fwd_data,
  input  logic [XLEN-1:0] i_wb_fwd_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_reg_write,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_mem_to_reg,
  input  logic            i_branch,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_alu_result,
  output logic            o_zero,
  output logic [XLEN-1:0] o_store_data,
  output logic [4:0]      o_rd_addr,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_mem_to_reg,
  output logic            o_branch_taken
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  always_comb begin
    op_a = i_rs1_data;
    case (i_fwd_a)
      FWD_MEM: op_a = i_mem_fwd_data;
      FWD_WB:  op_a = i_wb_fwd_data;
      default: op_a = i_rs1_data;
    endcase
  end

  always_comb begin
    fwd_b = i_rs2_data;
    case (i_fwd_b)
      FWD_MEM: fwd_b = i_mem_fwd_data;
      FWD_WB:  fwd_b = i_wb_fwd_data;
      default: fwd_b = i_rs2_data;
    endcase
  end

  // Store data taps the forwarded rs2 before the immediate mux.
  assign op_b = i_alu_src ? i_imm : fwd_b;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .alu_control (i_alu_control),
    .a           (op_a),
    .b           (op_b),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid        <= 1'b0;
      o_alu_result   <= '0;
      o_zero         <= 1'b0;
      o_store_data   <= '0;
      o_rd_addr      <= '0;
      o_reg_write    <= 1'b0;
      o_mem_read     <= 1'b0;
      o_mem_write    <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_branch_taken <= 1'b0;
    end else if (i_flush) begin
      o_valid        <= 1'b0;
      o_alu_result   <= '0;
      o_zero         <= 1'b0;
      o_store_data   <= '0;
      o_rd_addr      <= '0;
      o_reg_write    <= 1'b0;
      o_mem_read     <= 1'b0;
      o_mem_write    <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_branch_taken <= 1'b0;
    end else if (!i_stall) begin
      // An empty slot still carries its data fields, but never any side effect.
      o_valid        <= i_valid;
      o_alu_result   <= alu_result;
      o_zero         <= alu_zero;
      o_store_data   <= fwd_b;
      o_rd_addr      <= i_rd_addr;
      o_reg_write    <= i_valid & i_reg_write;
      o_mem_read     <= i_valid & i_mem_read;
      o_mem_write    <= i_valid & i_mem_write;
      o_mem_to_reg   <= i_mem_to_reg;
      o_branch_taken <= i_valid & i_branch & alu_zero;
    end
  end

endmodule

// File: tb/tb_execute_alu_stage.sv
// tb/tb_execute_alu_stage.sv - directed self-checking bench for execute_alu_stage
module tb_execute_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  alu_control;
  logic [31:0] rs1_data, rs2_data, imm, mem_fwd_data, wb_fwd_data;
  logic        alu_src;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_read, mem_write, mem_to_reg, branch;
  logic        stall, flush;
  logic        o_valid;
  logic [31:0] o_alu_result, o_store_data;
  logic        o_zero;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch_taken;

  int tests;
  int fails;

  execute_alu_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid),
    .i_alu_control  (alu_control),
    .i_rs1_data     (rs1_data),
    .i_rs2_data     (rs2_data),
    .i_imm          (imm),
    .i_alu_src      (alu_src),
    .i_fwd_a        (fwd_a),
    .i_fwd_b        (fwd_b),
    .i_mem_fwd_data (mem_fwd_data),
    .i_wb_fwd_data  (wb_fwd_data),
    .i_rd_addr      (rd_addr),
    .i_reg_write    (reg_write),
    .i_mem_read     (mem_read),
    .i_mem_write    (mem_write),
    .i_mem_to_reg   (mem_to_reg),
    .i_branch       (branch),
    .i_stall        (stall),
    .i_flush        (flush),
    .o_valid        (o_valid),
    .o_alu_result   (o_alu_result),
    .o_zero         (o_zero),
    .o_store_data   (o_store_data),
    .o_rd_addr      (o_rd_addr),
    .o_reg_write    (o_reg_write),
    .o_mem_read     (o_mem_read),
    .o_mem_write    (o_mem_write),
    .o_mem_to_reg   (o_mem_to_reg),
    .o_branch_taken (o_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; alu_control = 4'b0010; rs1_data = '0; rs2_data = '0; imm = '0;
    alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00; mem_fwd_data = '0; wb_fwd_data = '0;
    rd_addr = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    branch = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    idle();
    valid = 1'b1; reg_write = 1'b1; rd_addr = 5'd7; alu_control = op; rs1_data = a; rs2_data = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    tests++; if (o_valid !== 1'b0 || o_alu_result !== 32'h0 || o_reg_write !== 1'b0) begin
      fails++; $display("FAIL reset_hold valid=%b result=%h rw=%b exp 0/0/0", o_valid, o_alu_result, o_reg_write); end
    rst_n = 1'b1;
    alu_op(4'b0010, 32'h11, 32'h22); mem_to_reg = 1'b1; mem_read = 1'b1;
    step();
    tests++; if (o_alu_result !== 32'h33 || o_valid !== 1'b1) begin
      fails++; $display("FAIL reset_preload result=%h valid=%b exp 33/1", o_alu_result, o_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (o_valid !== 1'b0 || o_alu_result !== 32'h0 || o_rd_addr !== 5'd0 || o_reg_write !== 1'b0 ||
                 o_mem_read !== 1'b0 || o_mem_to_reg !== 1'b0 || o_zero !== 1'b0) begin
      fails++; $display("FAIL reset_async valid=%b result=%h rd=%0d rw=%b mr=%b m2r=%b z=%b exp all 0",
                        o_valid, o_alu_result, o_rd_addr, o_reg_write, o_mem_read, o_mem_to_reg, o_zero); end
    step();
    tests++; if (o_valid !== 1'b0 || o_alu_result !== 32'h0) begin
      fails++; $display("FAIL reset_edge valid=%b result=%h exp 0/0", o_valid, o_alu_result); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_alu();
    alu_op(4'b0010, 32'h7FFF_FFFF, 32'h1);
    step();
    tests++; if (o_alu_result !== 32'h8000_0000 || o_zero !== 1'b0 || o_rd_addr !== 5'd7 || o_reg_write !== 1'b1) begin
      fails++; $display("FAIL add_ovf result=%h zero=%b rd=%0d rw=%b exp 80000000/0/7/1", o_alu_result, o_zero, o_rd_addr, o_reg_write); end
    alu_op(4'b0010, 32'hFFFF_FFFF, 32'h1);
    step();
    tests++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1) begin
      fails++; $display("FAIL add_wrap result=%h zero=%b exp 0/1", o_alu_result, o_zero); end
    alu_op(4'b0110, 32'h5, 32'h5);
    step();
    tests++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1) begin
      fails++; $display("FAIL sub_eq result=%h zero=%b exp 0/1", o_alu_result, o_zero); end
    alu_op(4'b0110, 32'h3, 32'h5);
    step();
    tests++; if (o_alu_result !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL sub_neg result=%h exp fffffffe", o_alu_result); end
    alu_op(4'b0111, 32'hFFFF_FFFF, 32'h1);
    step();
    tests++; if (o_alu_result !== 32'h1 || o_zero !== 1'b0) begin
      fails++; $display("FAIL slt_signed result=%h zero=%b exp 1/0", o_alu_result, o_zero); end
    alu_op(4'b0111, 32'h1, 32'h8000_0000);
    step();
    tests++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1) begin
      fails++; $display("FAIL slt_false result=%h zero=%b exp 0/1", o_alu_result, o_zero); end
    alu_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    step();
    tests++; if (o_alu_result !== 32'h00F0_1200) begin
      fails++; $display("FAIL and result=%h exp 00f01200", o_alu_result); end
    alu_op(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00);
    step();
    tests++; if (o_alu_result !== 32'hFFF0_FF34) begin
      fails++; $display("FAIL or result=%h exp fff0ff34", o_alu_result); end
    alu_op(4'b1111, 32'h1234, 32'h5678);
    step();
    tests++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1) begin
      fails++; $display("FAIL unlisted result=%h zero=%b exp 0/1", o_alu_result, o_zero); end
  endtask

  task automatic test_forwarding();
    alu_op(4'b0010, 32'h1000, 32'h2000);
    fwd_a = 2'b10; mem_fwd_data = 32'h10; fwd_b = 2'b01; wb_fwd_data = 32'h3;
    step();
    tests++; if (o_alu_result !== 32'h13 || o_store_data !== 32'h3) begin
      fails++; $display("FAIL fwd_mem_wb result=%h store=%h exp 13/3", o_alu_result, o_store_data); end
    alu_op(4'b0010, 32'h20, 32'h5);
    fwd_a = 2'b11; fwd_b = 2'b00; mem_fwd_data = 32'h4000; wb_fwd_data = 32'h8000;
    step();
    tests++; if (o_alu_result !== 32'h25) begin
      fails++; $display("FAIL fwd_11 result=%h exp 25", o_alu_result); end
    alu_op(4'b0110, 32'h50, 32'h1);
    fwd_a = 2'b01; wb_fwd_data = 32'h30; fwd_b = 2'b10; mem_fwd_data = 32'h8;
    step();
    tests++; if (o_alu_result !== 32'h28 || o_store_data !== 32'h8) begin
      fails++; $display("FAIL fwd_wb_mem result=%h store=%h exp 28/8", o_alu_result, o_store_data); end
  endtask

  task automatic test_store();
    alu_op(4'b0010, 32'h100, 32'hAB);
    reg_write = 1'b0; mem_write = 1'b1; alu_src = 1'b1; imm = 32'h8;
    step();
    tests++; if (o_alu_result !== 32'h108 || o_store_data !== 32'hAB || o_mem_write !== 1'b1 || o_reg_write !== 1'b0) begin
      fails++; $display("FAIL store result=%h store=%h mw=%b rw=%b exp 108/ab/1/0", o_alu_result, o_store_data, o_mem_write, o_reg_write); end
    alu_op(4'b0010, 32'h200, 32'h1);
    alu_src = 1'b1; imm = 32'hFFFF_FFFC; mem_read = 1'b1; mem_to_reg = 1'b1;
    step();
    tests++; if (o_alu_result !== 32'h1FC || o_mem_read !== 1'b1 || o_mem_to_reg !== 1'b1 || o_store_data !== 32'h1) begin
      fails++; $display("FAIL load_negimm result=%h mr=%b m2r=%b store=%h exp 1fc/1/1/1", o_alu_result, o_mem_read, o_mem_to_reg, o_store_data); end
  endtask

  task automatic test_beq();
    alu_op(4'b0110, 32'h42, 32'h42);
    reg_write = 1'b0; branch = 1'b1;
    step();
    tests++; if (o_branch_taken !== 1'b1 || o_valid !== 1'b1 || o_zero !== 1'b1) begin
      fails++; $display("FAIL beq_taken bt=%b valid=%b zero=%b exp 1/1/1", o_branch_taken, o_valid, o_zero); end
    alu_op(4'b0110, 32'h42, 32'h43);
    reg_write = 1'b0; branch = 1'b1;
    step();
    tests++; if (o_branch_taken !== 1'b0 || o_zero !== 1'b0) begin
      fails++; $display("FAIL beq_not_taken bt=%b zero=%b exp 0/0", o_branch_taken, o_zero); end
    alu_op(4'b0110, 32'h42, 32'h42);
    valid = 1'b0; branch = 1'b1; reg_write = 1'b1; mem_write = 1'b1; mem_read = 1'b1; rd_addr = 5'd9;
    step();
    tests++; if (o_branch_taken !== 1'b0 || o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_mem_write !== 1'b0 ||
                 o_mem_read !== 1'b0 || o_zero !== 1'b1 || o_rd_addr !== 5'd9) begin
      fails++; $display("FAIL beq_invalid bt=%b valid=%b rw=%b mw=%b mr=%b zero=%b rd=%0d exp 0/0/0/0/0/1/9",
                        o_branch_taken, o_valid, o_reg_write, o_mem_write, o_mem_read, o_zero, o_rd_addr); end
  endtask

  task automatic test_stall_flush();
    alu_op(4'b0010, 32'h1, 32'h2);
    rd_addr = 5'd5;
    step();
    tests++; if (o_alu_result !== 32'h3 || o_rd_addr !== 5'd5) begin
      fails++; $display("FAIL stall_load result=%h rd=%0d exp 3/5", o_alu_result, o_rd_addr); end
    for (int k = 0; k < 3; k++) begin
      alu_op(4'b0001, 32'hA0 + k, 32'h0);
      rd_addr = 5'd12; stall = 1'b1;
      step();
      tests++; if (o_alu_result !== 32'h3 || o_rd_addr !== 5'd5 || o_valid !== 1'b1 || o_reg_write !== 1'b1) begin
        fails++; $display("FAIL stall_hold%0d result=%h rd=%0d valid=%b rw=%b exp 3/5/1/1", k, o_alu_result, o_rd_addr, o_valid, o_reg_write); end
    end
    alu_op(4'b0010, 32'h40, 32'h2);
    rd_addr = 5'd6;
    step();
    tests++; if (o_alu_result !== 32'h42 || o_rd_addr !== 5'd6) begin
      fails++; $display("FAIL stall_release result=%h rd=%0d exp 42/6", o_alu_result, o_rd_addr); end
    alu_op(4'b0010, 32'h7, 32'h8);
    mem_write = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    tests++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_mem_write !== 1'b0 || o_mem_read !== 1'b0 ||
                 o_branch_taken !== 1'b0 || o_alu_result !== 32'h0 || o_rd_addr !== 5'd0) begin
      fails++; $display("FAIL stall_flush valid=%b rw=%b mw=%b mr=%b bt=%b result=%h rd=%0d exp all 0",
                        o_valid, o_reg_write, o_mem_write, o_mem_read, o_branch_taken, o_alu_result, o_rd_addr); end
    alu_op(4'b0010, 32'h9, 32'h9);
    step();
    alu_op(4'b0010, 32'h1, 32'h1);
    flush = 1'b1;
    step();
    tests++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_alu_result !== 32'h0) begin
      fails++; $display("FAIL flush_only valid=%b rw=%b result=%h exp 0/0/0", o_valid, o_reg_write, o_alu_result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [4];
    exp_res[0] = 32'h3; exp_res[1] = 32'h7; exp_res[2] = 32'hB; exp_res[3] = 32'hF;
    for (int k = 0; k < 4; k++) begin
      alu_op(4'b0010, 32'(4 * k), 32'h3);
      rd_addr = 5'(k + 1);
      step();
      tests++; if (o_alu_result !== exp_res[k] || o_rd_addr !== 5'(k + 1) || o_valid !== 1'b1) begin
        fails++; $display("FAIL b2b%0d result=%h rd=%0d valid=%b exp %h/%0d/1", k, o_alu_result, o_rd_addr, o_valid, exp_res[k], k + 1); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alu();
    test_forwarding();
    test_store();
    test_beq();
    test_stall_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
